input_confirm_controller: RTL and testbench
===========================================

INPUT_CONFIRM_CONTROLLER -- requirements
Module: input_confirm_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the debounce qualification time in clk_50 cycles (50000 is about 1 ms at 50 MHz).
REQ-002 Parameter SW_W, default 16, SHALL set the switch bus width; SW_W SHALL be at most 32.
REQ-003 clk_50  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 FLAG_input  input  1  SHALL be the CPU input-request level; the CPU holds it high until the request is served.
REQ-006 push_confirm  input  1  SHALL be the raw, asynchronous, active-low confirm pushbutton.
REQ-007 switches  input  SW_W  SHALL be the user data switches.
REQ-008 FPGA_input_confirm  output  1  SHALL be the level acknowledgement returned to the CPU and clock controller.
REQ-009 input_data  output  32  SHALL be the latched, sign-extended switch value.
REQ-010 waiting  output  1  SHALL be the user-prompt LED, high while a request is pending.

Function
REQ-011 push_confirm SHALL pass through two flops (sync_a, then sync_b) before any use.
REQ-012 Debounce: while sync_b differs from stable, the counter SHALL increment each cycle; on the cycle it equals DEBOUNCE_CYCLES-1, stable SHALL take sync_b and the counter SHALL clear.
REQ-013 Any cycle with sync_b equal to stable SHALL clear the counter; glitches shorter than DEBOUNCE_CYCLES SHALL never change stable.
REQ-014 press_edge SHALL be combinational: stable_prev==1 and stable==0, where stable_prev is stable delayed one cycle.
REQ-015 The FSM SHALL have three states: IDLE, WAIT_PRESS and CONFIRMED.
REQ-016 IDLE -> WAIT_PRESS when FLAG_input==1; press_edge in IDLE SHALL be ignored.
REQ-017 WAIT_PRESS -> CONFIRMED on press_edge with FLAG_input==1; on that edge input_data SHALL load switches, sign-extended from bit SW_W-1.
REQ-018 WAIT_PRESS -> IDLE when FLAG_input==0 (abort); input_data SHALL be unchanged.
REQ-019 If the abort and press_edge occur in the same cycle, the abort SHALL win: no latch, no confirm.
REQ-020 CONFIRMED -> IDLE when FLAG_input==0; otherwise the FSM SHALL hold, and further presses SHALL be ignored.
REQ-021 FPGA_input_confirm SHALL be registered, equal to 1 exactly while the state is CONFIRMED.
REQ-022 waiting SHALL be registered, equal to 1 exactly while the state is WAIT_PRESS.
REQ-023 input_data SHALL hold its value until the next latch; it changes only on a WAIT_PRESS -> CONFIRMED transition.
REQ-024 Latency: with switches stable, the first rising edge that samples push_confirm==0 counts as edge 1; FPGA_input_confirm SHALL be high after edge DEBOUNCE_CYCLES+3.
REQ-025 A button held down across requests SHALL NOT confirm a new request; a fresh falling edge of stable is required.
REQ-026 A debounce counter width of 27 bits SHALL suffice for any DEBOUNCE_CYCLES below 2^27; the counter SHALL never wrap.

Reset
REQ-027 While reset==1 on a rising edge, the following SHALL apply:
- state SHALL go to IDLE
- FPGA_input_confirm, waiting and input_data SHALL go to 0
- sync_a, sync_b, stable and stable_prev SHALL go to 1
- the counter SHALL go to 0
REQ-028 reset SHALL override every other input, including mid-request and mid-debounce.
REQ-029 After reset, a still-high FLAG_input SHALL start a new request on the first non-reset edge.

Verification (DEBOUNCE_CYCLES=4, SW_W=16)
REQ-030 Normal request:
- Stimulus: FLAG_input=1; switches=16'h8005; push_confirm low from edge 1 onward.
- Response: waiting=1 one edge after FLAG_input rises; FPGA_input_confirm=1 and input_data=32'hFFFF8005 after edge 7; waiting=0 at the same edge.
REQ-031 Handshake release:
- Stimulus: in CONFIRMED, FLAG_input -> 0.
- Response: FPGA_input_confirm=0 after the next edge; input_data stays 32'hFFFF8005.
REQ-032 Glitch rejection:
- Stimulus: in WAIT_PRESS, push_confirm pulsed low for 3 cycles, then high.
- Response: stable unchanged; no confirm; waiting stays 1.
REQ-033 Abort:
- Stimulus: in WAIT_PRESS, FLAG_input drops in the same cycle press_edge fires.
- Response: IDLE; FPGA_input_confirm stays 0; input_data keeps its old value.
REQ-034 Held button:
- Stimulus: button held low through a completed request, then FLAG_input raised again.
- Response: waiting=1 and no confirm until the button is released for at least 4 cycles and pressed again.
REQ-035 Reset mid-operation:
- Stimulus: reset=1 for 1 cycle while in CONFIRMED with input_data=32'h00000005.
- Response: FPGA_input_confirm=0, waiting=0, input_data=0 after that edge; with FLAG_input still 1, waiting=1 one edge later.

Source files
------------

// File: rtl/input_confirm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : input_confirm_controller
//  Description : Debounces the active-low confirm pushbutton and runs the
//                CPU input-request handshake. It latches the switches,
//                sign-extended to 32 bits, on a fresh button press while a
//                request is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_confirm_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_W            = 16
) (
    input  logic            clk_50,
    input  logic            reset,
    input  logic            FLAG_input,
    input  logic            push_confirm,
    input  logic [SW_W-1:0] switches,
    output logic            FPGA_input_confirm,
    output logic [31:0]     input_data,
    output logic            waiting
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT      = 2'd1;
    localparam logic [1:0] c_ST_CONFIRMED = 2'd2;

    // 27 bits covers any qualification time below 2^27 cycles.
    localparam int                 c_CNT_W    = 27;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync_a;
    logic               r_sync_b;
    logic               r_stable;
    logic               r_stable_prev;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_press_edge;
    logic               w_latch;
    logic [31:0]        w_sext;

    // Sign-extend the switch bus to 32 bits from its top bit.
    generate
        if (SW_W < 32) begin : g_sext_pad
            assign w_sext = {{(32 - SW_W){switches[SW_W-1]}}, switches};
        end else begin : g_sext_full
            assign w_sext = switches[31:0];
        end
    endgenerate

    // Two-flop synchronizer followed by the counter-qualified debounce.
    // The idle level of the button is high.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_sync_a      <= 1'b1;
            r_sync_b      <= 1'b1;
            r_stable      <= 1'b1;
            r_stable_prev <= 1'b1;
            r_cnt         <= '0;
        end else begin
            r_sync_a      <= push_confirm;
            r_sync_b      <= r_sync_a;
            r_stable_prev <= r_stable;
            if (r_sync_b == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync_b;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // A press is a falling edge of the debounced level.
    assign w_press_edge = r_stable_prev & ~r_stable;

    // Next-state logic. An abort (flag low) takes priority over a press.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (FLAG_input) w_next_state = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (!FLAG_input) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_press_edge) begin
                    w_next_state = c_ST_CONFIRMED;
                    w_latch      = 1'b1;
                end
            end
            c_ST_CONFIRMED: begin
                if (!FLAG_input) w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // State register. The outputs are registered from the next state so that
    // each one tracks its state exactly, with no extra cycle of delay.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state            <= c_ST_IDLE;
            FPGA_input_confirm <= 1'b0;
            waiting            <= 1'b0;
            input_data         <= '0;
        end else begin
            r_state            <= w_next_state;
            FPGA_input_confirm <= (w_next_state == c_ST_CONFIRMED);
            waiting            <= (w_next_state == c_ST_WAIT);
            if (w_latch) input_data <= w_sext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_confirm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_confirm_controller
//  Description : Self-checking bench for input_confirm_controller. It runs
//                directed handshake scenarios, then randomized traffic,
//                against a behavioural request/debounce model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_confirm_controller;

    localparam int DB = 4;

    logic        clk_50;
    logic        reset;
    logic        FLAG_input;
    logic        push_confirm;
    logic [15:0] switches;
    logic        FPGA_input_confirm;
    logic [31:0] input_data;
    logic        waiting;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: the request phase, the debounced level and the
    // length of the current run of disagreeing samples.
    localparam int M_IDLE = 0, M_WAIT = 1, M_CONF = 2;
    int          m_phase  = M_IDLE;
    bit          m_stable = 1'b1;
    bit          m_prev   = 1'b1;
    int          m_run    = 0;
    bit          m_q[$];           // raw samples still inside the 2-flop delay
    logic [31:0] m_data   = '0;

    input_confirm_controller #(
        .DEBOUNCE_CYCLES(DB),
        .SW_W           (16)
    ) dut (
        .clk_50            (clk_50),
        .reset             (reset),
        .FLAG_input        (FLAG_input),
        .push_confirm      (push_confirm),
        .switches          (switches),
        .FPGA_input_confirm(FPGA_input_confirm),
        .input_data        (input_data),
        .waiting           (waiting)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // One clock edge: advance the model with the sampled inputs, then compare
    // every output a little after the edge.
    task automatic tick();
        bit sb;
        bit press;
        @(posedge clk_50);
        if (reset) begin
            m_phase  = M_IDLE;
            m_stable = 1'b1;
            m_prev   = 1'b1;
            m_run    = 0;
            m_data   = '0;
            m_q      = '{1'b1, 1'b1};
        end else begin
            press = m_prev && !m_stable;
            case (m_phase)
                M_IDLE: if (FLAG_input) m_phase = M_WAIT;
                M_WAIT: begin
                    if (!FLAG_input) m_phase = M_IDLE;
                    else if (press) begin
                        m_phase = M_CONF;
                        m_data  = switches[15] ? {16'hFFFF, switches} : {16'h0000, switches};
                    end
                end
                default: if (!FLAG_input) m_phase = M_IDLE;
            endcase
            sb     = m_q[0];
            m_prev = m_stable;
            if (sb != m_stable) begin
                m_run++;
                if (m_run == DB) begin
                    m_stable = sb;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
            void'(m_q.pop_front());
            m_q.push_back(push_confirm);
        end
        #1;
        chk("model_confirm", {31'd0, FPGA_input_confirm}, (m_phase == M_CONF) ? 32'd1 : 32'd0);
        chk("model_waiting", {31'd0, waiting}, (m_phase == M_WAIT) ? 32'd1 : 32'd0);
        chk("model_data", input_data, m_data);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int hold;
        m_q = '{1'b1, 1'b1};
        reset        = 1'b1;
        FLAG_input   = 1'b0;
        push_confirm = 1'b1;
        switches     = 16'h0000;
        ticks(2);
        chk("reset_confirm", {31'd0, FPGA_input_confirm}, 32'd0);
        chk("reset_waiting", {31'd0, waiting}, 32'd0);
        chk("reset_data", input_data, 32'd0);

        // Normal request: waiting one edge after the flag; confirm at edge 7.
        reset      = 1'b0;
        FLAG_input = 1'b1;
        switches   = 16'h8005;
        tick();
        chk("req_waiting", {31'd0, waiting}, 32'd1);
        push_confirm = 1'b0;
        ticks(6);
        chk("latency_e6_confirm", {31'd0, FPGA_input_confirm}, 32'd0);
        tick();
        chk("latency_e7_confirm", {31'd0, FPGA_input_confirm}, 32'd1);
        chk("latency_e7_data", input_data, 32'hFFFF8005);
        chk("latency_e7_waiting", {31'd0, waiting}, 32'd0);

        // Handshake release, with the button still held down.
        FLAG_input = 1'b0;
        tick();
        chk("release_confirm", {31'd0, FPGA_input_confirm}, 32'd0);
        chk("release_data", input_data, 32'hFFFF8005);

        // A held button must not confirm a new request.
        FLAG_input = 1'b1;
        switches   = 16'h0005;
        ticks(12);
        chk("held_waiting", {31'd0, waiting}, 32'd1);
        chk("held_confirm", {31'd0, FPGA_input_confirm}, 32'd0);
        push_confirm = 1'b1;
        ticks(8);
        push_confirm = 1'b0;
        ticks(6);
        chk("repress_e6_confirm", {31'd0, FPGA_input_confirm}, 32'd0);
        tick();
        chk("repress_e7_confirm", {31'd0, FPGA_input_confirm}, 32'd1);
        chk("repress_data", input_data, 32'h00000005);

        // Reset while confirmed; the still-high flag restarts a request.
        reset = 1'b1;
        tick();
        chk("midreset_confirm", {31'd0, FPGA_input_confirm}, 32'd0);
        chk("midreset_waiting", {31'd0, waiting}, 32'd0);
        chk("midreset_data", input_data, 32'd0);
        reset        = 1'b0;
        push_confirm = 1'b1;
        tick();
        chk("postreset_waiting", {31'd0, waiting}, 32'd1);

        // Glitch of 3 cycles is rejected.
        ticks(3);
        push_confirm = 1'b0;
        ticks(3);
        push_confirm = 1'b1;
        ticks(8);
        chk("glitch_waiting", {31'd0, waiting}, 32'd1);
        chk("glitch_confirm", {31'd0, FPGA_input_confirm}, 32'd0);

        // Abort in the same cycle that the press edge appears.
        switches     = 16'h7777;
        push_confirm = 1'b0;
        ticks(6);
        FLAG_input = 1'b0;
        tick();
        chk("abort_confirm", {31'd0, FPGA_input_confirm}, 32'd0);
        chk("abort_waiting", {31'd0, waiting}, 32'd0);
        chk("abort_data", input_data, 32'd0);

        // Randomized traffic against the model.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                push_confirm = 1'($urandom_range(0, 1));
                hold         = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 19) == 0) FLAG_input = ~FLAG_input;
            switches = 16'($urandom);
            reset    = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
